pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Physical-memory responder for the cache-line pmem interface. It services
//  pmem_read/pmem_write line requests from a cache controller and answers
//  each one with a one-cycle pmem_resp after a programmable latency.
//  Backing store is an on-chip array of 128-bit lines. Sits below the
//  I/D cache controllers (directly, or behind an arbiter) as the memory end.
// PARAMETERS
//  LATENCY     4   cycles spent in BUSY per request; legal range 1..255
//  INDEX_BITS  5   log2 of line count; array holds 2**INDEX_BITS x 128b lines
// PORTS
//  clk           in   1    clock, all state updates on rising edge
//  rst_n         in   1    asynchronous active-low reset
//  pmem_read     in   1    line read request, held until pmem_resp
//  pmem_write    in   1    line write request, held until pmem_resp
//  pmem_address  in   16   byte address; line = [15:4], index = [4+INDEX_BITS-1:4]
//  pmem_wdata    in   128  write line data, valid with pmem_write
//  pmem_rdata    out  128  read line data, valid while pmem_resp=1 on a read
//  pmem_resp     out  1    one-cycle completion pulse
//  proto_err     out  1    sticky protocol-violation flag
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, pmem_resp=0, pmem_rdata=0,
//   proto_err=0; any latched request is discarded (pending write NOT
//   committed). Array contents are not reset (X until first written).
//  States: IDLE, BUSY, RESP. pmem_resp = (state==RESP), a registered decode.
//  IDLE: if pmem_read|pmem_write at an edge -> latch op, index, wdata;
//   cnt<=LATENCY-1; go BUSY. If both are high: op=write, proto_err<=1.
//  BUSY: cnt==0 -> RESP, else cnt<=cnt-1. Inputs ignored (latched copy used).
//   If the request drops, or the op changes, during BUSY: proto_err<=1; the
//   transaction still completes.
//  BUSY->RESP edge: a write commits the latched wdata to array[index]; a read
//   loads pmem_rdata<=array[index]. pmem_rdata holds until the next read
//   completes (writes do not change it).
//  RESP: pmem_resp=1 for exactly one cycle; inputs ignored; always -> IDLE.
//   The initiator still drives the old request in this cycle, so it is never
//   re-sampled as new.
//  Timing: a request first sampled at edge N gives pmem_resp high in the
//   cycle after edge N+LATENCY. Back-to-back requests are accepted from the
//   IDLE cycle after RESP, so there is LATENCY+2 cycles per request min.
//  Write then read of the same line returns the new data. Addresses above the
//   array alias modulo 2**INDEX_BITS. Bits [3:0] are ignored.
//  cnt is 8 bits wide; LATENCY=1 means a single BUSY cycle.
//  proto_err is cleared only by reset.
// TESTING
//  T1 read latency: reset, write line 0x0040=0x0123..EF, then read 0x0040
//     with LATENCY=4 -> resp 4 cycles after the IDLE edge, rdata matches,
//     resp width=1.
//  T2 dirty-evict pattern: write 0x1230 then the read held high the cycle
//     after resp -> two distinct transactions, two resp pulses, read returns
//     the pre-existing line.
//  T3 aliasing: INDEX_BITS=5, write 0x0010=A, read 0x0210 -> A.
//  T4 violations: read&write together -> treated as write, proto_err=1;
//     read dropped mid-BUSY -> resp still pulses, proto_err stays 1.
//  T5 reset mid-write: assert rst_n=0 during BUSY of a write to 0x0050 ->
//     resp=0 immediately; a later read of 0x0050 returns the old contents.
//  T6 LATENCY=1: read -> resp in the cycle after edge N+1; 100 random
//     read/write ops match the scoreboard.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Cache-line physical-memory responder: a 128-bit-line backing array that
// answers each held pmem_read/pmem_write with a one-cycle pmem_resp after LATENCY cycles.
module pmem_line_responder #(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned INDEX_BITS = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic [127:0] pmem_rdata,
   output logic         pmem_resp,
   output logic         proto_err
);

   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  op_q, op_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic [127:0]          wdata_q, wdata_d;
   logic [127:0]          rdata_q, rdata_d;
   logic                  proto_err_q, proto_err_d;
   logic                  mem_we;
   logic [127:0]          mem [LINES];
   logic                  unused_addr;

   assign unused_addr = ^{pmem_address[3:0], pmem_address[15:4+INDEX_BITS]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      proto_err_d = proto_err_q;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pmem_read | pmem_write) begin
               op_d    = pmem_write;
               idx_d   = pmem_address[4 +: INDEX_BITS];
               wdata_d = pmem_wdata;
               cnt_d   = CNT_INIT;
               state_d = BUSY;
               if (pmem_read & pmem_write) proto_err_d = 1'b1;
            end
         end
         BUSY: begin
            // write wins when both are high, so the live op is pmem_write
            if (!(pmem_read | pmem_write) || (pmem_write != op_q)) proto_err_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = RESP;
               if (op_q) mem_we = 1'b1;
               else      rdata_d = mem[idx_q];
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Array is not reset; mem_we derives from state_q, so an async reset blocks the commit.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= wdata_q;
   end

   assign pmem_resp  = (state_q == RESP);
   assign pmem_rdata = rdata_q;
   assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: vector table plus hand-written
// corner sequences, with a scoreboard queue of expected responses.
module tb_pmem_line_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sel;
   logic         rd, wr;
   logic [15:0]  addr;
   logic [127:0] wdata;
   logic         rd4, wr4, rd1, wr1;
   logic [127:0] rdata4, rdata1, rdata;
   logic         resp4, resp1, resp;
   logic         perr4, perr1, perr;

   always #5 clk = ~clk;

   assign rd4   = rd & ~sel;
   assign wr4   = wr & ~sel;
   assign rd1   = rd & sel;
   assign wr1   = wr & sel;
   assign resp  = sel ? resp1  : resp4;
   assign rdata = sel ? rdata1 : rdata4;
   assign perr  = sel ? perr1  : perr4;

   pmem_line_responder #(.LATENCY(4), .INDEX_BITS(5)) dut (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd4), .pmem_write(wr4),
      .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata4),
      .pmem_resp(resp4), .proto_err(perr4)
   );

   pmem_line_responder #(.LATENCY(1), .INDEX_BITS(5)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
      .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata1),
      .pmem_resp(resp1), .proto_err(perr1)
   );

   typedef struct {
      logic [127:0] rdata;
      int           lat;
   } exp_t;

   typedef struct {
      bit           w;
      bit           r;
      logic [15:0]  a;
      logic [127:0] d;
      logic [127:0] exp;
      string        name;
   } vec_t;

   int           checks = 0;
   int           passed = 0;
   exp_t         sb[$];
   logic [127:0] last_rd;
   logic [127:0] model_mem [32];
   vec_t         vecs [9];

   localparam logic [127:0] D1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] DA = 128'hAAAA0000_11112222_33334444_55556666;
   localparam logic [127:0] DB = 128'hBBBBBBBB_00000001_DEADBEEF_CAFEF00D;
   localparam logic [127:0] DC = 128'hC0C0C0C0_12301230_0BADF00D_77778888;
   localparam logic [127:0] DG = 128'h50505050_A5A5A5A5_5A5A5A5A_00500050;
   localparam logic [127:0] DE = 128'hEEEE1111_2222EEEE_60606060_13579BDF;
   localparam logic [127:0] DF = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rd    = 1'b0;
      wr    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      last_rd = '0;
   endtask

   // Entered and left at #1 after a rising edge with the DUT idle.
   task automatic do_txn(input bit is_wr, input bit is_rd, input logic [15:0] a,
                         input logic [127:0] d, input logic [127:0] exp_rd,
                         input bit hold_after, input int drop_at, input string name);
      exp_t e;
      int   k;
      bit   got;
      e.lat   = sel ? 1 : 4;
      e.rdata = (is_rd && !is_wr) ? exp_rd : last_rd;
      if (is_rd && !is_wr) last_rd = exp_rd;
      sb.push_back(e);
      rd    = is_rd;
      wr    = is_wr;
      addr  = a;
      wdata = d;
      @(posedge clk); #1;
      k   = 0;
      got = 1'b0;
      while (!got && k < 300) begin
         if (drop_at != 0 && k == drop_at) begin
            rd = 1'b0;
            wr = 1'b0;
         end
         @(posedge clk); #1;
         k++;
         if (resp) got = 1'b1;
      end
      e = sb.pop_front();
      check({name, "_resp_seen"}, 128'(got), 128'd1);
      if (got) begin
         check({name, "_lat"}, 128'(k), 128'(e.lat));
         check({name, "_rdata"}, rdata, e.rdata);
         @(negedge clk);
         if (!hold_after) begin
            rd = 1'b0;
            wr = 1'b0;
         end
         @(posedge clk); #1;
         check({name, "_resp_width"}, 128'(resp), 128'd0);
      end else begin
         rd = 1'b0;
         wr = 1'b0;
      end
   endtask

   initial begin
      int   pulses;
      bit   seen;
      logic [15:0]  ra;
      logic [127:0] rv;
      rst_n = 1'b0;
      sel   = 1'b0;
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
      last_rd = '0;

      vecs[0] = '{1'b1, 1'b0, 16'h0040, D1, '0, "t1_wr_0040"};
      vecs[1] = '{1'b0, 1'b1, 16'h0040, '0, D1, "t1_rd_0040"};
      vecs[2] = '{1'b1, 1'b0, 16'h0010, DA, '0, "t3_wr_0010"};
      vecs[3] = '{1'b0, 1'b1, 16'h0210, '0, DA, "t3_rd_0210_alias"};
      vecs[4] = '{1'b1, 1'b0, 16'h1230, DB, '0, "wr_1230"};
      vecs[5] = '{1'b0, 1'b1, 16'h003F, '0, DB, "rd_003f_alias"};
      vecs[6] = '{1'b0, 1'b1, 16'h0040, '0, D1, "rd_0040_again"};
      vecs[7] = '{1'b1, 1'b0, 16'h0050, DG, '0, "wr_0050"};
      vecs[8] = '{1'b0, 1'b1, 16'h0450, '0, DG, "rd_0450_alias"};

      do_reset();
      check("rst_resp_l4",  128'(resp4), 128'd0);
      check("rst_rdata_l4", rdata4,      128'd0);
      check("rst_perr_l4",  128'(perr4), 128'd0);
      check("rst_resp_l1",  128'(resp1), 128'd0);
      check("rst_rdata_l1", rdata1,      128'd0);
      check("rst_perr_l1",  128'(perr1), 128'd0);

      for (int i = 0; i < 9; i++)
         do_txn(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp, 1'b0, 0, vecs[i].name);
      check("clean_perr", 128'(perr), 128'd0);

      // T2: write request still high through RESP, read follows in the IDLE cycle
      do_txn(1'b1, 1'b0, 16'h1230, DC, '0, 1'b1, 0, "t2_evict_wr");
      do_txn(1'b0, 1'b1, 16'h0040, '0, D1, 1'b0, 0, "t2_fill_rd");
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (resp) pulses++;
      end
      check("t2_no_extra_resp", 128'(pulses), 128'd0);
      do_txn(1'b0, 1'b1, 16'h0030, '0, DC, 1'b0, 0, "t2_rd_evicted");

      // T4: simultaneous read and write is a write plus a sticky error
      do_txn(1'b1, 1'b1, 16'h0060, DE, '0, 1'b0, 0, "t4_both");
      check("t4_perr_both", 128'(perr), 128'd1);
      do_txn(1'b0, 1'b1, 16'h0060, '0, DE, 1'b0, 0, "t4_rd_back");
      do_reset();
      check("t4_perr_cleared", 128'(perr), 128'd0);
      do_txn(1'b0, 1'b1, 16'h0040, '0, D1, 1'b0, 2, "t4_drop");
      check("t4_perr_drop", 128'(perr), 128'd1);
      do_txn(1'b0, 1'b1, 16'h0010, '0, DA, 1'b0, 0, "t4_clean_after");
      check("t4_perr_sticky", 128'(perr), 128'd1);

      // T5: reset during BUSY of a write discards it
      rd = 1'b0; wr = 1'b1; addr = 16'h0050; wdata = DF;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("t5_resp_rst",  128'(resp), 128'd0);
      check("t5_perr_rst",  128'(perr), 128'd0);
      check("t5_rdata_rst", rdata,      128'd0);
      wr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      last_rd = '0;
      do_txn(1'b0, 1'b1, 16'h0050, '0, DG, 1'b0, 0, "t5_rd_old");

      // reset landing in the RESP cycle kills the pulse asynchronously
      rd = 1'b1; addr = 16'h0040;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (resp) seen = 1'b1;
      end
      check("t5b_resp_seen", 128'(seen), 128'd1);
      check("t5b_rdata_before", rdata, D1);
      rst_n = 1'b0;
      #1;
      check("t5b_resp_rst",  128'(resp), 128'd0);
      check("t5b_rdata_rst", rdata,      128'd0);
      rd = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      last_rd = '0;

      // T6: LATENCY=1 instance with a line model
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         rv = {$urandom, $urandom, $urandom, $urandom};
         model_mem[i] = rv;
         do_txn(1'b1, 1'b0, 16'(i << 4), rv, '0, 1'b0, 0, "t6_fill");
      end
      do_txn(1'b0, 1'b1, 16'h0040, '0, model_mem[4], 1'b0, 0, "t6_rd_0040");
      for (int n = 0; n < 100; n++) begin
         ra = 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            model_mem[ra[8:4]] = rv;
            do_txn(1'b1, 1'b0, ra, rv, '0, 1'b0, 0, "t6_rand_wr");
         end else begin
            do_txn(1'b0, 1'b1, ra, '0, model_mem[ra[8:4]], 1'b0, 0, "t6_rand_rd");
         end
      end
      check("t6_perr", 128'(perr), 128'd0);
      check("t6_sb_empty", 128'(sb.size()), 128'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
